filter_frame_sched: RTL and testbench



---
 rtl/filter_frame_sched_pkg.sv | 22 ++
 rtl/filter_frame_sched_coef_shadow.sv | 38 +++
 rtl/filter_frame_sched.sv | 168 ++++++++++++++++
 tb/tb_filter_frame_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_frame_sched_pkg.sv
// Shared definitions for the video filter frame controller and its neighbours
// (window generator, LCD controller).
package filter_frame_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int ERR_W     = 3;
    localparam int ERR_TMO   = 0;
    localparam int ERR_ADDR  = 1;
    localparam int ERR_STRAY = 2;

    localparam int WIDTH_DEF  = 480;
    localparam int HEIGHT_DEF = 272;
    localparam int DEPTH_DEF  = WIDTH_DEF * HEIGHT_DEF;

endpackage

// File: rtl/filter_frame_sched_coef_shadow.sv
// Four 32-bit shadow registers captured on a load strobe; lets a filter stage
// see a coefficient set that cannot change underneath a frame.
module coef_shadow_regs (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] coef0_i,
    input  logic [31:0] coef1_i,
    input  logic [31:0] coef2_i,
    input  logic [31:0] coef3_i,
    output logic [31:0] coef0_o,
    output logic [31:0] coef1_o,
    output logic [31:0] coef2_o,
    output logic [31:0] coef3_o
);

    logic [31:0] coef0_q, coef1_q, coef2_q, coef3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coef0_q <= '0;
            coef1_q <= '0;
            coef2_q <= '0;
            coef3_q <= '0;
        end else if (load_i) begin
            coef0_q <= coef0_i;
            coef1_q <= coef1_i;
            coef2_q <= coef2_i;
            coef3_q <= coef3_i;
        end
    end

    assign coef0_o = coef0_q;
    assign coef1_o = coef1_q;
    assign coef2_o = coef2_q;
    assign coef3_o = coef3_q;

endmodule

// File: rtl/filter_frame_sched.sv
// Frame sequencer for the filter pipeline: start pulse, coefficient shadowing,
// frame completion counting, watchdog and sticky error reporting.
//   state | meaning
//   IDLE  | waiting for trigger / continuous / pending request
//   LOAD  | shadow coefficients being captured
//   START | start pulse out, pixel counter cleared
//   RUN   | counting write strobes, watchdog armed
//   GAP   | inter-frame idle time (done cycle + GAP_CYC cycles)
module filter_frame_sched
    import filter_frame_sched_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int HEIGHT  = HEIGHT_DEF,
    parameter int DEPTH   = WIDTH * HEIGHT,
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEnable,
    input  logic              iContinuous,
    input  logic              iTrig,
    input  logic              iClrErr,
    input  logic [31:0]       iCoef0,
    input  logic [31:0]       iCoef1,
    input  logic [31:0]       iCoef2,
    input  logic [31:0]       iCoef3,
    input  logic              iPixValid,
    input  logic [ADDR_W-1:0] iPixAddr,
    output logic              oStart,
    output logic [31:0]       oCoef0,
    output logic [31:0]       oCoef1,
    output logic [31:0]       oCoef2,
    output logic [31:0]       oCoef3,
    output logic              oBusy,
    output logic              oDone,
    output logic [15:0]       oFrameCnt,
    output logic [ERR_W-1:0]  oErr
);

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DEPTH - 1);
    localparam logic [WD_W-1:0]   WD_LOAD  = WD_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               pending_q, pending_d;
    logic               start_q, busy_q;
    logic               done_q, done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [ERR_W-1:0]   err_q, err_d, err_set;
    logic               load_coef;

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        wdog_d      = wdog_q;
        gap_d       = gap_q;
        pending_d   = pending_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_set     = '0;

        if (iTrig && state_q != ST_IDLE) pending_d = 1'b1;
        if (iPixValid && state_q != ST_RUN) err_set[ERR_STRAY] = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (iEnable && (iTrig || iContinuous || pending_q)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                pix_cnt_d = '0;
                wdog_d    = WD_LOAD;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                if (iPixValid) begin
                    if (iPixAddr != pix_cnt_q) err_set[ERR_ADDR] = 1'b1;
                    wdog_d = WD_LOAD;
                    if (pix_cnt_q == LAST_PIX) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gap_d       = GAP_LOAD;
                        state_d     = ST_GAP;
                    end else begin
                        pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                    end
                end else if (wdog_q == '0) begin
                    err_set[ERR_TMO] = 1'b1;
                    pending_d        = 1'b0;
                    state_d          = ST_IDLE;
                end else begin
                    wdog_d = wdog_q - WD_W'(1);
                end
            end
            ST_GAP: begin
                // the oDone cycle is spent here before the GAP_CYC counted cycles
                if (gap_q == '0) begin
                    state_d = (iEnable && (iContinuous || pending_q)) ? ST_LOAD : ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_LOAD) pending_d = 1'b0;

        err_d     = (err_q & ~{ERR_W{iClrErr}}) | err_set;
        load_coef = (state_q == ST_LOAD);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            pix_cnt_q   <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
            pending_q   <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            pending_q   <= pending_d;
            start_q     <= (state_d == ST_START);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    coef_shadow_regs u_coef_shadow (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .load_i  (load_coef),
        .coef0_i (iCoef0),
        .coef1_i (iCoef1),
        .coef2_i (iCoef2),
        .coef3_i (iCoef3),
        .coef0_o (oCoef0),
        .coef1_o (oCoef1),
        .coef2_o (oCoef2),
        .coef3_o (oCoef3)
    );

    assign oStart    = start_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oFrameCnt = frame_cnt_q;
    assign oErr      = err_q;

endmodule

// File: tb/tb_filter_frame_sched.sv
// Bench for filter_frame_sched: timeline reference model checked every cycle,
// a table of single-shot frames, and directed multi-cycle sequences.
module tb_filter_frame_sched;

    localparam int ADDR_W  = 17;
    localparam int DEPTH   = 16;
    localparam int GAP_CYC = 16;
    localparam int TIMEOUT = 4096;

    localparam int P_IDLE = 0, P_LOAD = 1, P_START = 2, P_RUN = 3, P_GAP = 4;

    logic              iClk = 1'b0;
    logic              iRst, iEnable, iContinuous, iTrig, iClrErr, iPixValid;
    logic [31:0]       iCoef0, iCoef1, iCoef2, iCoef3;
    logic [ADDR_W-1:0] iPixAddr;
    logic              oStart, oBusy, oDone;
    logic [31:0]       oCoef0, oCoef1, oCoef2, oCoef3;
    logic [15:0]       oFrameCnt;
    logic [2:0]        oErr;

    filter_frame_sched #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iContinuous(iContinuous),
        .iTrig(iTrig), .iClrErr(iClrErr),
        .iCoef0(iCoef0), .iCoef1(iCoef1), .iCoef2(iCoef2), .iCoef3(iCoef3),
        .iPixValid(iPixValid), .iPixAddr(iPixAddr),
        .oStart(oStart), .oCoef0(oCoef0), .oCoef1(oCoef1), .oCoef2(oCoef2), .oCoef3(oCoef3),
        .oBusy(oBusy), .oDone(oDone), .oFrameCnt(oFrameCnt), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // reference model: frame timeline kept as absolute edge stamps
    bit          m_busy, m_gap, m_pend, m_start, m_done;
    int          m_tload, m_tref, m_tdone, m_n;
    logic [2:0]  m_err;
    logic [15:0] m_fc;
    logic [31:0] m_coef [4];

    int k_edge = 0;
    int last_trig_edge, last_start_edge, last_done_edge, last_pv_edge, err0_edge;
    int start_cnt = 0, done_cnt = 0;
    bit prev_e0 = 1'b0;

    task automatic model_reset();
        m_busy = 0; m_gap = 0; m_pend = 0; m_start = 0; m_done = 0;
        m_tload = -100; m_tref = 0; m_tdone = 0; m_n = 0;
        m_err = '0; m_fc = '0;
        for (int i = 0; i < 4; i++) m_coef[i] = '0;
    endtask

    function automatic int phase_at(input int k);
        if (!m_busy) return P_IDLE;
        if (m_gap) return P_GAP;
        if (k == m_tload + 1) return P_LOAD;
        if (k == m_tload + 2) return P_START;
        return P_RUN;
    endfunction

    task automatic model_edge(input int k, input bit en, input bit cont, input bit trig,
                              input bit clr, input bit pv, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [31:0] c3);
        int ph;
        logic [2:0] newerr;
        bit clear_pend;
        ph = phase_at(k);
        newerr = '0;
        clear_pend = 0;
        m_done = 0;
        if (pv && ph != P_RUN) newerr[2] = 1'b1;
        case (ph)
            P_IDLE: if (en && (trig || cont || m_pend)) begin
                m_busy = 1; m_gap = 0; m_tload = k; clear_pend = 1;
            end
            P_LOAD: begin
                m_coef[0] = c0; m_coef[1] = c1; m_coef[2] = c2; m_coef[3] = c3;
            end
            P_START: begin
                m_n = 0; m_tref = k;
            end
            P_RUN: begin
                if (pv) begin
                    if (int'(addr) != m_n) newerr[1] = 1'b1;
                    m_tref = k;
                    m_n++;
                    if (m_n == DEPTH) begin
                        m_done = 1; m_fc = m_fc + 16'd1; m_gap = 1; m_tdone = k;
                    end
                end else if (k == m_tref + TIMEOUT) begin
                    newerr[0] = 1'b1; m_busy = 0; clear_pend = 1;
                end
            end
            default: if (k == m_tdone + GAP_CYC + 1) begin
                m_gap = 0;
                if (en && (cont || m_pend)) begin
                    m_tload = k; clear_pend = 1;
                end else begin
                    m_busy = 0;
                end
            end
        endcase
        if (clear_pend) m_pend = 0;
        else if (trig && ph != P_IDLE) m_pend = 1;
        m_err = (m_err & ~{3{clr}}) | newerr;
        m_start = m_busy && !m_gap && (k == m_tload + 1);
    endtask

    always begin
        @(posedge iClk);
        k_edge++;
        if (iPixValid) last_pv_edge = k_edge;
        if (iTrig) last_trig_edge = k_edge;
        if (iRst) model_reset();
        else model_edge(k_edge, iEnable, iContinuous, iTrig, iClrErr, iPixValid, iPixAddr,
                        iCoef0, iCoef1, iCoef2, iCoef3);
        #1;
        check("mdl_start", 32'(oStart), 32'(m_start));
        check("mdl_busy", 32'(oBusy), 32'(m_busy));
        check("mdl_done", 32'(oDone), 32'(m_done));
        check("mdl_frame_cnt", 32'(oFrameCnt), 32'(m_fc));
        check("mdl_err", 32'(oErr), 32'(m_err));
        check("mdl_coef0", oCoef0, m_coef[0]);
        check("mdl_coef1", oCoef1, m_coef[1]);
        check("mdl_coef2", oCoef2, m_coef[2]);
        check("mdl_coef3", oCoef3, m_coef[3]);
        if (oStart) begin last_start_edge = k_edge; start_cnt++; end
        if (oDone) begin last_done_edge = k_edge; done_cnt++; end
        if (oErr[0] && !prev_e0) err0_edge = k_edge;
        prev_e0 = oErr[0];
    end

    task automatic cyc(); @(negedge iClk); endtask
    task automatic pulse_trig(); iTrig = 1; cyc(); iTrig = 0; endtask
    task automatic pulse_clr(); iClrErr = 1; cyc(); iClrErr = 0; endtask

    task automatic wait_start(input int budget);
        int c = 0;
        while (!oStart && c < budget) begin cyc(); c++; end
        check("wait_start_bound", 32'(oStart), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (oBusy && c < budget) begin cyc(); c++; end
        check("wait_idle_bound", 32'(oBusy), 32'd0);
    endtask

    task automatic feed(input int first, input int cnt, input int bad);
        for (int i = first; i < first + cnt; i++) begin
            iPixValid = 1;
            iPixAddr  = ADDR_W'((i == bad) ? i + 1 : i);
            cyc();
            iPixValid = 0;
            if (i < first + cnt - 1) repeat ($urandom_range(0, 2)) cyc();
        end
    endtask

    typedef struct {
        int       bad;
        bit       clr;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl [5];
    int   frames = 0;
    int   s0, d0;

    initial begin
        tbl[0] = '{bad: -1, clr: 0, exp_err: 3'b000};
        tbl[1] = '{bad:  4, clr: 0, exp_err: 3'b010};
        tbl[2] = '{bad: -1, clr: 1, exp_err: 3'b000};
        tbl[3] = '{bad: 15, clr: 0, exp_err: 3'b010};
        tbl[4] = '{bad:  0, clr: 1, exp_err: 3'b010};

        iRst = 1; iEnable = 0; iContinuous = 0; iTrig = 0; iClrErr = 0; iPixValid = 0;
        iPixAddr = '0; iCoef0 = 32'h0; iCoef1 = 32'hA1; iCoef2 = 32'hB2; iCoef3 = 32'hC3;
        repeat (3) cyc();
        iRst = 0;
        check("rst_start", 32'(oStart), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_frame_cnt", 32'(oFrameCnt), 0);
        check("rst_err", 32'(oErr), 0);
        check("rst_coef0", oCoef0, 0);

        // trigger while disabled is ignored and leaves nothing pending
        pulse_trig();
        repeat (4) cyc();
        check("trig_disabled_busy", 32'(oBusy), 0);
        iEnable = 1;
        repeat (3) cyc();
        check("trig_disabled_no_pending", 32'(start_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].clr) pulse_clr();
            iCoef1 = $urandom;
            pulse_trig();
            wait_start(10);
            check("start_latency", 32'(last_start_edge - last_trig_edge), 1);
            check("start_coef1", oCoef1, iCoef1);
            cyc();
            feed(0, DEPTH, tbl[i].bad);
            frames++;
            check("done_pulse", 32'(oDone), 1);
            wait_idle(GAP_CYC + 10);
            check("tbl_err", 32'(oErr), 32'(tbl[i].exp_err));
            check("tbl_frame_cnt", 32'(oFrameCnt), 32'(frames));
            check("tbl_done_cnt", 32'(done_cnt), 32'(frames));
        end

        // coefficient writes during RUN must not tear the frame
        pulse_clr();
        iCoef0 = 32'h11;
        pulse_trig();
        wait_start(10);
        check("tear_coef_at_start", oCoef0, 32'h11);
        cyc();
        feed(0, 8, -1);
        iCoef0 = 32'h22;
        feed(8, 8, -1);
        frames++;
        check("tear_coef_in_gap", oCoef0, 32'h11);
        wait_idle(GAP_CYC + 10);
        check("tear_coef_idle", oCoef0, 32'h11);
        pulse_trig();
        wait_start(10);
        check("tear_coef_next_load", oCoef0, 32'h22);
        cyc();
        feed(0, DEPTH, -1);
        frames++;
        wait_idle(GAP_CYC + 10);

        // continuous mode, dropped during the third frame
        s0 = start_cnt;
        iContinuous = 1;
        wait_start(10);
        cyc();
        feed(0, DEPTH, -1);
        frames++;
        for (int f = 1; f < 3; f++) begin
            wait_start(GAP_CYC + 10);
            check("cont_start_after_done", 32'(last_start_edge - last_done_edge), 32'(GAP_CYC + 2));
            cyc();
            feed(0, 8, -1);
            if (f == 2) iContinuous = 0;
            feed(8, 8, -1);
            frames++;
        end
        wait_idle(GAP_CYC + 10);
        check("cont_starts", 32'(start_cnt - s0), 3);
        check("cont_frame_cnt", 32'(oFrameCnt), 32'(frames));
        check("cont_err", 32'(oErr), 0);

        // watchdog
        d0 = done_cnt;
        pulse_trig();
        wait_start(10);
        cyc();
        feed(0, 3, -1);
        wait_idle(TIMEOUT + 20);
        check("tmo_err", 32'(oErr), 32'b001);
        check("tmo_no_done", 32'(done_cnt), 32'(d0));
        check("tmo_frame_cnt", 32'(oFrameCnt), 32'(frames));
        check("tmo_delay", 32'(err0_edge - last_pv_edge), 32'(TIMEOUT));
        pulse_clr();
        check("clr_err", 32'(oErr), 0);

        // stray strobe in IDLE, then triggers during RUN leave one pending frame
        iPixValid = 1; iPixAddr = '0; cyc(); iPixValid = 0;
        check("stray_err", 32'(oErr), 32'b100);
        s0 = start_cnt;
        pulse_trig();
        wait_start(10);
        cyc();
        feed(0, 5, -1);
        pulse_trig();
        pulse_trig();
        feed(5, 11, -1);
        frames++;
        wait_start(GAP_CYC + 10);
        check("pending_start_after_done", 32'(last_start_edge - last_done_edge), 32'(GAP_CYC + 2));
        cyc();
        feed(0, DEPTH, -1);
        frames++;
        wait_idle(GAP_CYC + 10);
        repeat (5) cyc();
        check("pending_one_deep", 32'(start_cnt - s0), 2);
        check("pending_frame_cnt", 32'(oFrameCnt), 32'(frames));
        check("pending_err", 32'(oErr), 32'b100);

        // reset in the middle of a frame
        pulse_trig();
        wait_start(10);
        cyc();
        feed(0, 7, -1);
        iRst = 1; cyc(); iRst = 0;
        frames = 0;
        check("midrst_busy", 32'(oBusy), 0);
        check("midrst_start", 32'(oStart), 0);
        check("midrst_frame_cnt", 32'(oFrameCnt), 0);
        check("midrst_err", 32'(oErr), 0);
        check("midrst_coef1", oCoef1, 0);
        pulse_trig();
        wait_start(10);
        cyc();
        feed(0, DEPTH, -1);
        frames++;
        wait_idle(GAP_CYC + 10);
        check("midrst_restart_err", 32'(oErr), 0);
        check("midrst_restart_fc", 32'(oFrameCnt), 32'(frames));

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            iEnable     = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) iContinuous = ~iContinuous;
            iTrig       = ($urandom_range(0, 15) == 0);
            iClrErr     = ($urandom_range(0, 63) == 0);
            iPixValid   = ($urandom_range(0, 1) == 1);
            iPixAddr    = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, 31)) : ADDR_W'(m_n);
            iRst        = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 7) == 0) begin
                iCoef0 = $urandom; iCoef1 = $urandom; iCoef2 = $urandom; iCoef3 = $urandom;
            end
            cyc();
        end
        iTrig = 0; iClrErr = 0; iPixValid = 0; iContinuous = 0; iRst = 1;
        cyc();
        iRst = 0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
